display_frame_sequencer: RTL and testbench
==========================================

Name: display_frame_sequencer

Overview:
Owns the display SPI pins and time-shares them between two sources: host command bytes (init, mode and power commands) and pixel frames from the pixel serializer.
For each frame it shifts the ST7735-style window preamble (CASET, RASET, RAMWR) itself, then pulses the serializer start and muxes the serializer's mosi/sck onto the pins until the frame completes.
Sits between the host command path, the frame-ready logic and the display SPI pins.

Parameters:
WIDTH, 128, visible columns
HEIGHT, 128, visible rows
X_OFFSET, 0, panel column offset added to window start/end
Y_OFFSET, 0, panel row offset added to window start/end
CLK_DIV, 1, sck half-period in clk cycles (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
cmd_valid  in  1  host command byte valid
cmd_ready  out  1  command byte accepted when valid&&ready
cmd_data  in  9  bit8 = dc level, bits7:0 = byte
frame_req  in  1  one-cycle request to send a frame
busy  out  1  state != IDLE or frame pending
frame_done  out  1  one-cycle pulse at end of frame
pix_start  out  1  one-cycle start pulse to pixel serializer
pix_mosi  in  1  serializer data
pix_sck  in  1  serializer clock
pix_done  in  1  one-cycle pulse: last pixel bit shifted
spi_mosi  out  1  display data
spi_sck  out  1  display clock, idle low (mode 0)
spi_dc  out  1  0 = command, 1 = data
spi_cs_n  out  1  display chip select, active low

Behaviour:
- Reset values:
  - cmd_ready=0, busy=0, frame_done=0, pix_start=0
  - spi_mosi=0, spi_sck=0, spi_dc=0, spi_cs_n=1
  - frame_pending=0, state=IDLE
- Reset mid-transfer aborts immediately to these values; no partial byte is completed.
- States: IDLE, CMD_SHIFT, WIN_SHIFT, PIX_START, PIX_RUN, CS_GAP.
- frame_pending:
  - Set on frame_req in any state; cleared when WIN_SHIFT is entered.
  - A second frame_req while already pending is dropped (one-deep).
- IDLE:
  - cmd_ready=1 in IDLE only.
  - cmd_valid has priority: latch cmd_data, go to CMD_SHIFT.
  - Otherwise, if frame_pending, load window byte index 0 and go to WIN_SHIFT.
- Byte shifter (shared by CMD_SHIFT and WIN_SHIFT):
  - MSB first; spi_cs_n=0; spi_dc held for the whole byte.
  - First cycle of a byte: mosi=bit7, sck=0.
  - sck toggles every CLK_DIV cycles; mosi updates on each falling edge.
  - A byte occupies exactly 16*CLK_DIV cycles, ending with sck low.
- CMD_SHIFT: after the byte, go to CS_GAP. cs_n deasserts between host bytes.
- WIN_SHIFT: 11 bytes back-to-back, no cs gap:
  - 0x2A (dc=0)
  - xs_hi, xs_lo, xe_hi, xe_lo (dc=1)
  - 0x2B (dc=0)
  - ys_hi, ys_lo, ye_hi, ye_lo (dc=1)
  - 0x2C (dc=0)
  - Coordinates: xs=X_OFFSET, xe=X_OFFSET+WIDTH-1, ys=Y_OFFSET, ye=Y_OFFSET+HEIGHT-1, all 16-bit unsigned, computed at elaboration.
  - After 0x2C, go to PIX_START.
- PIX_START: pix_start=1 for one cycle, dc=1, cs_n=0; then PIX_RUN.
- PIX_RUN:
  - spi_mosi=pix_mosi, spi_sck=pix_sck (combinational mux), dc=1, cs_n=0.
  - On pix_done: go to CS_GAP with frame_done=1 for one cycle.
  - pix_done in any other state is ignored.
- CS_GAP: cs_n=1, sck=0 for 2 cycles, then IDLE.
- Latency:
  - Command: cmd accept -> cs_n high again is 16*CLK_DIV+1 cycles.
  - Frame: frame_req in IDLE -> pix_start is 1+176*CLK_DIV cycles.
- frame_req during PIX_RUN sets pending; the next frame starts after CS_GAP unless cmd_valid wins in IDLE.

Test Plan:
- Reset, then idle 10 cycles -> cs_n=1, sck=0, cmd_ready=1, busy=0, no pix_start.
- CLK_DIV=1, cmd_data=9'h011 -> dc=0, bits 0,0,0,1,0,0,0,1 sampled on 8 sck rising edges; cs_n low for 16 cycles, then high 2 cycles; cmd_ready=1 again.
- CLK_DIV=2, WIDTH=128, X_OFFSET=2, Y_OFFSET=1, frame_req -> bytes 2A,00,02,00,81,2B,00,01,00,80,2C with correct dc per byte; pix_start exactly 1+352 cycles after frame_req; cs_n low continuously.
- Same setup, drive pix_done 40 cycles after pix_start -> frame_done pulse, cs_n high 2 cycles, busy drops; pix_mosi/pix_sck visible on pins only during PIX_RUN.
- cmd_valid and frame_req asserted in the same IDLE cycle -> command byte shifted first, then window preamble; a second frame_req during PIX_RUN -> exactly one extra frame; a third frame_req in the same window is dropped.
- Reset asserted mid-WIN_SHIFT (byte 5) -> next cycle cs_n=1, sck=0, busy=0, pending cleared; no pix_start afterwards.

Source files
------------

// File: rtl/display_frame_sequencer.sv
// Display SPI pin owner: shifts host command bytes and the per-frame window
// preamble itself, then hands the pins to the pixel serializer for the frame body.
module display_frame_sequencer #(
  parameter int unsigned WIDTH    = 128,
  parameter int unsigned HEIGHT   = 128,
  parameter int unsigned X_OFFSET = 0,
  parameter int unsigned Y_OFFSET = 0,
  parameter int unsigned CLK_DIV  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [8:0] cmd_data,
  input  logic       frame_req,
  output logic       busy,
  output logic       frame_done,
  output logic       pix_start,
  input  logic       pix_mosi,
  input  logic       pix_sck,
  input  logic       pix_done,
  output logic       spi_mosi,
  output logic       spi_sck,
  output logic       spi_dc,
  output logic       spi_cs_n
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [15:0] XS = 16'(X_OFFSET);
  localparam logic [15:0] XE = 16'(X_OFFSET + WIDTH - 1);
  localparam logic [15:0] YS = 16'(Y_OFFSET);
  localparam logic [15:0] YE = 16'(Y_OFFSET + HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD_SHIFT,
    WIN_SHIFT,
    PIX_START,
    PIX_RUN,
    CS_GAP
  } state_t;

  state_t state, stateNext;

  logic             framePending;
  logic [8:0]       cmdLatch;
  logic [3:0]       winIdx;
  logic [3:0]       halfIdx;
  logic [DIV_W-1:0] divCnt;
  logic             gapCnt;

  logic             halfEnd;
  logic             byteEnd;
  logic             winLast;
  logic             enterWin;
  logic [7:0]       winByte;
  logic             winDc;
  logic [7:0]       txByte;
  logic             txDc;

  // A byte is 16 sck half-periods; odd halves drive sck high.
  assign halfEnd  = (divCnt == DIV_LAST);
  assign byteEnd  = halfEnd && (halfIdx == 4'd15);
  assign winLast  = (winIdx == 4'd10);
  assign enterWin = (state == IDLE) && (stateNext == WIN_SHIFT);

  assign txByte = (state == CMD_SHIFT) ? cmdLatch[7:0] : winByte;
  assign txDc   = (state == CMD_SHIFT) ? cmdLatch[8]   : winDc;

  assign cmd_ready = (state == IDLE) && !reset;
  assign busy      = (state != IDLE) || framePending;

  // Window preamble table: CASET, RASET, RAMWR with their coordinate bytes.
  always_comb begin
    winByte = 8'h00;
    winDc   = 1'b1;
    case (winIdx)
      4'd0:    begin winByte = 8'h2A; winDc = 1'b0; end
      4'd1:    winByte = XS[15:8];
      4'd2:    winByte = XS[7:0];
      4'd3:    winByte = XE[15:8];
      4'd4:    winByte = XE[7:0];
      4'd5:    begin winByte = 8'h2B; winDc = 1'b0; end
      4'd6:    winByte = YS[15:8];
      4'd7:    winByte = YS[7:0];
      4'd8:    winByte = YE[15:8];
      4'd9:    winByte = YE[7:0];
      4'd10:   begin winByte = 8'h2C; winDc = 1'b0; end
      default: winByte = 8'h00;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // Next-state logic and pin drive; the serializer owns the pins only in PIX_RUN.
  always_comb begin
    stateNext  = state;
    spi_mosi   = 1'b0;
    spi_sck    = 1'b0;
    spi_dc     = 1'b0;
    spi_cs_n   = 1'b1;
    pix_start  = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (cmd_valid)                      stateNext = CMD_SHIFT;
        else if (framePending || frame_req) stateNext = WIN_SHIFT;
      end
      CMD_SHIFT, WIN_SHIFT: begin
        spi_cs_n = 1'b0;
        spi_dc   = txDc;
        spi_mosi = txByte[3'd7 - halfIdx[3:1]];
        spi_sck  = halfIdx[0];
        if (byteEnd) begin
          if (state == CMD_SHIFT) stateNext = CS_GAP;
          else if (winLast)       stateNext = PIX_START;
        end
      end
      PIX_START: begin
        spi_cs_n  = 1'b0;
        spi_dc    = 1'b1;
        pix_start = 1'b1;
        stateNext = PIX_RUN;
      end
      PIX_RUN: begin
        spi_cs_n = 1'b0;
        spi_dc   = 1'b1;
        spi_mosi = pix_mosi;
        spi_sck  = pix_sck;
        if (pix_done) begin
          frame_done = 1'b1;
          stateNext  = CS_GAP;
        end
      end
      CS_GAP: begin
        if (gapCnt) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Bit timing and window byte counters; held at zero outside the shifter states.
  always_ff @(posedge clk) begin
    if (reset) begin
      divCnt  <= '0;
      halfIdx <= '0;
      winIdx  <= '0;
      gapCnt  <= 1'b0;
    end else begin
      if (state == CMD_SHIFT || state == WIN_SHIFT) begin
        divCnt <= halfEnd ? '0 : divCnt + 1'b1;
        if (halfEnd) halfIdx <= halfIdx + 1'b1;
        if (byteEnd && state == WIN_SHIFT) winIdx <= winIdx + 1'b1;
      end else begin
        divCnt  <= '0;
        halfIdx <= '0;
        winIdx  <= '0;
      end
      gapCnt <= (state == CS_GAP) ? ~gapCnt : 1'b0;
    end
  end

  // Host byte capture on accept.
  always_ff @(posedge clk) begin
    if (reset)                        cmdLatch <= '0;
    else if (state == IDLE && cmd_valid) cmdLatch <= cmd_data;
  end

  // One-deep frame request; a request consumed directly from IDLE never sets it.
  always_ff @(posedge clk) begin
    if (reset)          framePending <= 1'b0;
    else if (enterWin)  framePending <= 1'b0;
    else if (frame_req) framePending <= 1'b1;
  end

endmodule

// File: tb/tb_display_frame_sequencer.sv
// Randomized self-checking bench for display_frame_sequencer.
module tb_display_frame_sequencer;

  localparam int W  = 128;
  localparam int H  = 128;
  localparam int XO = 2;
  localparam int YO = 1;
  localparam int D  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [8:0] cmd_data = '0;
  logic       frame_req = 1'b0;
  logic       busy;
  logic       frame_done;
  logic       pix_start;
  logic       pix_mosi = 1'b0;
  logic       pix_sck = 1'b0;
  logic       pix_done = 1'b0;
  logic       spi_mosi;
  logic       spi_sck;
  logic       spi_dc;
  logic       spi_cs_n;

  display_frame_sequencer #(
    .WIDTH(W), .HEIGHT(H), .X_OFFSET(XO), .Y_OFFSET(YO), .CLK_DIV(D)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .frame_req(frame_req), .busy(busy), .frame_done(frame_done),
    .pix_start(pix_start), .pix_mosi(pix_mosi), .pix_sck(pix_sck), .pix_done(pix_done),
    .spi_mosi(spi_mosi), .spi_sck(spi_sck), .spi_dc(spi_dc), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pixStartCnt = 0, lastPixStartCyc = 0;
  int frameDoneCnt = 0, lastFrameDoneCyc = 0;
  int csRiseCnt = 0, lastCsRiseCyc = 0;
  int cmdAccCyc = 0;
  logic [9:0] obsQ[$];
  logic [9:0] expQ[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Serializer pins toggle randomly all the time; they must reach the panel only in PIX_RUN.
  initial forever begin
    @(posedge clk); #1;
    pix_mosi = 1'($urandom_range(0, 1));
    pix_sck  = 1'($urandom_range(0, 1));
  end

  // Pin monitor: decodes SPI bytes, checks the pixel mux and records event cycles.
  initial begin
    int bitCnt;
    bit pixPhase, prevSck, prevCs, curDc, curGl;
    logic [7:0] curByte;
    bitCnt = 0; pixPhase = 0; prevSck = 0; prevCs = 1; curDc = 0; curGl = 0; curByte = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        bitCnt = 0; pixPhase = 0; prevSck = 0; prevCs = 1;
      end else begin
        if (pix_start) begin pixStartCnt++; lastPixStartCyc = cyc; end
        if (frame_done) begin frameDoneCnt++; lastFrameDoneCyc = cyc; end
        if (spi_cs_n && !prevCs) begin csRiseCnt++; lastCsRiseCyc = cyc; end
        if (spi_cs_n) check("sckIdle", 32'(spi_sck), 32'd0);
        if (pixPhase) begin
          check("muxMosi", 32'(spi_mosi), 32'(pix_mosi));
          check("muxSck", 32'(spi_sck), 32'(pix_sck));
          check("muxDc", 32'(spi_dc), 32'd1);
        end else if (!spi_cs_n && spi_sck && !prevSck) begin
          if (bitCnt == 0) begin curDc = spi_dc; curGl = 0; end
          else if (spi_dc != curDc) curGl = 1;
          curByte = {curByte[6:0], spi_mosi};
          bitCnt++;
          if (bitCnt == 8) begin
            obsQ.push_back({curGl, curDc, curByte});
            bitCnt = 0;
          end
        end
        if (pix_start) pixPhase = 1;
        else if (frame_done) pixPhase = 0;
        prevSck = spi_sck;
        prevCs  = spi_cs_n;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Advance one cycle; pulses last one cycle, cmd_valid holds until accepted.
  task automatic step();
    bit acc;
    acc = cmd_valid && cmd_ready;
    if (acc) cmdAccCyc = cyc;
    @(posedge clk); #1;
    if (acc) cmd_valid = 1'b0;
    frame_req = 1'b0;
    pix_done  = 1'b0;
  endtask

  // Panel window preamble for the bench parameters.
  function automatic void pushWindow();
    int xs, xe, ys, ye;
    xs = XO; xe = XO + W - 1; ys = YO; ye = YO + H - 1;
    expQ.push_back(10'h02A);
    expQ.push_back({2'b01, 8'(xs >> 8)}); expQ.push_back({2'b01, 8'(xs)});
    expQ.push_back({2'b01, 8'(xe >> 8)}); expQ.push_back({2'b01, 8'(xe)});
    expQ.push_back(10'h02B);
    expQ.push_back({2'b01, 8'(ys >> 8)}); expQ.push_back({2'b01, 8'(ys)});
    expQ.push_back({2'b01, 8'(ye >> 8)}); expQ.push_back({2'b01, 8'(ye)});
    expQ.push_back(10'h02C);
  endfunction

  task automatic compareBytes();
    check("byteCount", 32'(obsQ.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++)
      check($sformatf("byte%0d", i), 32'(obsQ[i]), 32'(expQ[i]));
    obsQ.delete();
    expQ.delete();
  endtask

  task automatic waitStart(input int target);
    int n;
    n = 0;
    while (pixStartCnt < target && n < 3000) begin step(); n++; end
    check("startWait", pixStartCnt, target);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while ((busy || cmd_valid) && n < 3000) begin step(); n++; end
    check("idleWait", 32'({busy, cmd_valid}), 32'd0);
  endtask

  // Runs PIX_RUN for d cycles after pix_start, optionally injecting requests.
  task automatic runPix(input int d, input int extra, input bit lateCmd,
                        input logic [8:0] c1, output int pdCyc);
    for (int i = 0; i < d - 1; i++) begin
      if (i < 3 * extra && (i % 3) == 0) frame_req = 1'b1;
      if (lateCmd && i == 1) begin cmd_data = c1; cmd_valid = 1'b1; end
      step();
    end
    pix_done = 1'b1;
    pdCyc = cyc;
    step();
    check("frameDoneCyc", lastFrameDoneCyc, pdCyc);
  endtask

  task automatic doTxn(input bit wantCmd, input bit wantFrame, input bit lateCmd,
                       input int extra, input int pd1);
    int st0, fd0, cr0, frames, cmds, pdCyc, reqCyc;
    logic [8:0] c0, c1;
    st0 = pixStartCnt; fd0 = frameDoneCnt; cr0 = csRiseCnt;
    frames = 0; cmds = 0;
    c0 = 9'($urandom_range(0, 511));
    c1 = 9'($urandom_range(0, 511));
    if (wantCmd) begin
      cmd_data = c0; cmd_valid = 1'b1;
      expQ.push_back({1'b0, c0}); cmds++;
    end
    if (wantFrame) begin
      frame_req = 1'b1;
      pushWindow(); frames++;
    end
    reqCyc = cyc;
    step();
    if (!wantFrame) begin
      waitIdle();
      check("cmdCsRise", lastCsRiseCyc - cmdAccCyc, 16 * D + 1);
    end else begin
      waitStart(st0 + 1);
      check("frameLat", lastPixStartCyc - reqCyc, wantCmd ? 16 * D + 4 + 176 * D : 1 + 176 * D);
      runPix(pd1, extra, lateCmd, c1, pdCyc);
      if (lateCmd) begin expQ.push_back({1'b0, c1}); cmds++; end
      if (extra > 0) begin
        pushWindow(); frames++;
        waitStart(st0 + 2);
        check("reFrameLat", lastPixStartCyc - pdCyc,
              lateCmd ? 7 + 16 * D + 176 * D : 4 + 176 * D);
        runPix($urandom_range(2, 30), 0, 1'b0, c1, pdCyc);
      end
      waitIdle();
    end
    repeat (10) step();
    check("pixStarts", pixStartCnt - st0, frames);
    check("frameDones", frameDoneCnt - fd0, frames);
    check("csRises", csRiseCnt - cr0, frames + cmds);
    check("idleReady", 32'(cmd_ready), 32'd1);
    check("idleBusy", 32'(busy), 32'd0);
    compareBytes();
  endtask

  initial begin
    int acc, st0, n;
    repeat (3) step();
    check("rstCs", 32'(spi_cs_n), 32'd1);
    check("rstSck", 32'(spi_sck), 32'd0);
    check("rstMosi", 32'(spi_mosi), 32'd0);
    check("rstDc", 32'(spi_dc), 32'd0);
    check("rstReady", 32'(cmd_ready), 32'd0);
    check("rstBusy", 32'(busy), 32'd0);
    check("rstStart", 32'(pix_start), 32'd0);
    check("rstDone", 32'(frame_done), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idleCs", 32'(spi_cs_n), 32'd1);
      check("idleReady0", 32'(cmd_ready), 32'd1);
      check("idleBusy0", 32'(busy), 32'd0);
    end
    check("noStart", pixStartCnt, 0);

    // Single command byte with gap timing.
    cmd_data = 9'h011; cmd_valid = 1'b1;
    expQ.push_back(10'h011);
    step();
    acc = cmdAccCyc;
    n = 0;
    while (cyc < acc + 16 * D && n < 100) begin
      check("cmdCsLow", 32'(spi_cs_n), 32'd0);
      step(); n++;
    end
    check("cmdCsLowEnd", 32'(spi_cs_n), 32'd0);
    step();
    check("gap1Cs", 32'(spi_cs_n), 32'd1);
    check("gap1Ready", 32'(cmd_ready), 32'd0);
    step();
    check("gap2Cs", 32'(spi_cs_n), 32'd1);
    check("gap2Ready", 32'(cmd_ready), 32'd0);
    step();
    check("readyAgain", 32'(cmd_ready), 32'd1);
    compareBytes();

    // Directed frame, pix_done 40 cycles after pix_start.
    doTxn(1'b0, 1'b1, 1'b0, 0, 40);
    // Command and frame together, extra and dropped requests during PIX_RUN.
    doTxn(1'b1, 1'b1, 1'b0, 2, 30);
    doTxn(1'b0, 1'b1, 1'b1, 3, 25);

    for (int t = 0; t < 14; t++) begin
      int mode;
      mode = $urandom_range(0, 2);
      doTxn(mode != 1, mode != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3), $urandom_range(8, 60));
    end

    // Reset while shifting the fifth window byte.
    st0 = pixStartCnt;
    frame_req = 1'b1;
    step();
    n = 0;
    while (obsQ.size() < 4 && n < 1000) begin step(); n++; end
    check("abortReach", 32'(obsQ.size()), 32'd4);
    repeat (10) step();
    reset = 1'b1;
    step();
    check("abortCs", 32'(spi_cs_n), 32'd1);
    check("abortSck", 32'(spi_sck), 32'd0);
    check("abortBusy", 32'(busy), 32'd0);
    check("abortReady", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (i % 50 == 0) check("abortIdleBusy", 32'(busy), 32'd0);
    end
    check("abortNoStart", pixStartCnt, st0);
    check("abortCsIdle", 32'(spi_cs_n), 32'd1);
    pushWindow();
    while (expQ.size() > 4) void'(expQ.pop_back());
    compareBytes();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
